// File: rtl/if_fetch_buffer_pkg.sv
// Shared fetch-stage definitions: the data width, the default substitute instruction,
// and the entry that travels from a buffer slot to decode.
package if_fetch_buffer_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            fault;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_buffer_fetch_slot_queue.sv
// In-order slot queue for fetched instructions. Slots are allocated at the tail,
// filled in order by memory responses, and popped from the head by decode.
module fetch_slot_queue
    import if_fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear_i,
    input  logic            alloc_i,
    input  fetch_entry_t    alloc_entry_i,
    input  logic            alloc_filled_i,
    input  logic            fill_i,
    input  logic [XLEN-1:0] fill_instr_i,
    input  logic            pop_i,
    output logic            tail_free_o,
    output logic            head_valid_o,
    output fetch_entry_t    head_entry_o
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t     ent_q [DEPTH];
    fetch_entry_t     ent_d [DEPTH];
    logic [DEPTH-1:0] alloc_q, alloc_d;
    logic [DEPTH-1:0] filled_q, filled_d;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [PW-1:0]    fill_ptr_s;
    logic [PW-1:0]    idx_s;
    logic             fill_found_s;

    // Fill pointer: oldest allocated slot still waiting for its word. Slots that were
    // pre-filled at allocation (misaligned fetches) are skipped naturally.
    always_comb begin
        fill_ptr_s   = head_q;
        fill_found_s = 1'b0;
        idx_s        = head_q;
        for (int i = 0; i < DEPTH; i++) begin
            idx_s = head_q + PW'(i);
            if (!fill_found_s && alloc_q[idx_s] && !filled_q[idx_s]) begin
                fill_ptr_s   = idx_s;
                fill_found_s = 1'b1;
            end else begin
                fill_found_s = fill_found_s;
            end
        end
    end

    // Slot next-state: clear dominates; otherwise pop, fill and alloc touch distinct slots.
    always_comb begin
        ent_d    = ent_q;
        alloc_d  = alloc_q;
        filled_d = filled_q;
        head_d   = head_q;
        tail_d   = tail_q;
        if (clear_i) begin
            alloc_d  = {DEPTH{1'b0}};
            filled_d = {DEPTH{1'b0}};
            head_d   = {PW{1'b0}};
            tail_d   = {PW{1'b0}};
        end else begin
            if (pop_i) begin
                alloc_d[head_q]  = 1'b0;
                filled_d[head_q] = 1'b0;
                head_d           = head_q + PW'(1);
            end else begin
                head_d = head_q;
            end
            if (fill_i && fill_found_s) begin
                ent_d[fill_ptr_s].instr = fill_instr_i;
                filled_d[fill_ptr_s]    = 1'b1;
            end else begin
                filled_d = filled_d;
            end
            if (alloc_i) begin
                ent_d[tail_q]    = alloc_entry_i;
                alloc_d[tail_q]  = 1'b1;
                filled_d[tail_q] = alloc_filled_i;
                tail_d           = tail_q + PW'(1);
            end else begin
                tail_d = tail_q;
            end
        end
    end

    // Slot storage and pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            alloc_q  <= {DEPTH{1'b0}};
            filled_q <= {DEPTH{1'b0}};
            head_q   <= {PW{1'b0}};
            tail_q   <= {PW{1'b0}};
        end else begin
            ent_q    <= ent_d;
            alloc_q  <= alloc_d;
            filled_q <= filled_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
        end
    end

    assign tail_free_o  = ~alloc_q[tail_q];
    assign head_valid_o = alloc_q[head_q] & filled_q[head_q];
    assign head_entry_o = ent_q[head_q];

endmodule

// File: rtl/if_fetch_buffer.sv
// Instruction-fetch buffer: issues in-order memory requests for the PC stream, queues
// returned words with their PC, and discards stale responses after a redirect.
module if_fetch_buffer
    import if_fetch_buffer_pkg::XLEN;
    import if_fetch_buffer_pkg::fetch_entry_t;
#(
    parameter int              DEPTH     = 2,
    parameter int              MAX_OUT   = 2,
    parameter logic [XLEN-1:0] NOP_INSTR = if_fetch_buffer_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    input  logic            pc_valid,
    output logic            pc_ready,
    input  logic            flush,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_instr,
    output logic            id_fault
);

    localparam int            CW        = $clog2(MAX_OUT) + 1;
    localparam logic [CW:0]   MAX_OUT_C = (CW + 1)'(MAX_OUT);

    logic [CW-1:0] live_out_q, live_out_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW:0]   inflight_s;
    logic          aligned_s, credit_s, can_acc_s, issue_s;
    logic          rsp_drop_s, rsp_fill_s, pop_s, tail_free_s, head_valid_s;
    fetch_entry_t  alloc_entry_s, head_entry_s;

    assign aligned_s  = (pc[1:0] == 2'b00);
    assign inflight_s = {1'b0, live_out_q} + {1'b0, drop_cnt_q};
    assign credit_s   = (inflight_s < MAX_OUT_C);
    // Outputs are forced quiet while reset is held, even though the PC stage may be valid.
    assign can_acc_s  = ~rst & pc_valid & ~flush & tail_free_s;

    assign imem_req_valid = can_acc_s & aligned_s & credit_s;
    assign imem_req_addr  = pc;
    assign issue_s        = imem_req_valid & imem_req_ready;
    assign pc_ready       = aligned_s ? issue_s : can_acc_s;

    assign rsp_drop_s = imem_rsp_valid & (drop_cnt_q != {CW{1'b0}});
    assign rsp_fill_s = imem_rsp_valid & (drop_cnt_q == {CW{1'b0}});

    assign alloc_entry_s.pc    = pc;
    assign alloc_entry_s.instr = aligned_s ? {XLEN{1'b0}} : NOP_INSTR;
    assign alloc_entry_s.fault = ~aligned_s;

    assign pop_s = head_valid_s & id_ready;

    fetch_slot_queue #(
        .DEPTH (DEPTH)
    ) u_slot_queue (
        .clk            (clk),
        .rst            (rst),
        .clear_i        (flush),
        .alloc_i        (pc_ready),
        .alloc_entry_i  (alloc_entry_s),
        .alloc_filled_i (~aligned_s),
        .fill_i         (rsp_fill_s),
        .fill_instr_i   (imem_rsp_data),
        .pop_i          (pop_s),
        .tail_free_o    (tail_free_s),
        .head_valid_o   (head_valid_s),
        .head_entry_o   (head_entry_s)
    );

    // Credit bookkeeping: a flush converts every live request into one that must be dropped,
    // less any response that lands in the flush cycle itself.
    always_comb begin
        live_out_d = live_out_q;
        drop_cnt_d = drop_cnt_q;
        if (flush) begin
            live_out_d = {CW{1'b0}};
            drop_cnt_d = drop_cnt_q + live_out_q - {{(CW-1){1'b0}}, imem_rsp_valid};
        end else begin
            live_out_d = live_out_q + {{(CW-1){1'b0}}, issue_s} - {{(CW-1){1'b0}}, rsp_fill_s};
            drop_cnt_d = drop_cnt_q - {{(CW-1){1'b0}}, rsp_drop_s};
        end
    end

    // Counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_out_q <= {CW{1'b0}};
            drop_cnt_q <= {CW{1'b0}};
        end else begin
            live_out_q <= live_out_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign id_valid = head_valid_s;
    assign id_pc    = head_entry_s.pc;
    assign id_instr = head_entry_s.instr;
    assign id_fault = head_entry_s.fault;

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Scoreboard bench for if_fetch_buffer: a driver pushes expected entries on accept,
// a memory model answers requests, and a monitor checks every decode handshake.
`timescale 1ns/1ps
module tb_if_fetch_buffer;

    localparam int MAX_OUT = 2;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        pc_valid;
    logic        pc_ready;
    logic        flush;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_fault;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    exp_t  exp_q[$];
    pend_t pend_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    mem_lat  = 1;

    if_fetch_buffer #(
        .DEPTH     (2),
        .MAX_OUT   (MAX_OUT),
        .NOP_INSTR (32'h0000_0013)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pc             (pc),
        .pc_valid       (pc_valid),
        .pc_ready       (pc_ready),
        .flush          (flush),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .id_fault       (id_fault)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Memory: drives one in-order response per cycle at negedge, records handshakes late in the cycle.
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        forever begin
            @(negedge clk);
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_word(pend_q[0].addr);
                void'(pend_q.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
            end
            #8;
            if (!rst && imem_req_valid && imem_req_ready) begin
                pend_q.push_back('{imem_req_addr, cyc + mem_lat});
            end
        end
    end

    // Monitor: every decode handshake must match the oldest expected entry.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && id_valid && id_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got pc %h instr %h, expected no entry", id_pc, id_instr);
                end else begin
                    e = exp_q.pop_front();
                    check("id_entry", {id_pc, id_instr, id_fault}, {e.pc, e.instr, e.fault});
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic fetch(input logic [31:0] a);
        bit   done;
        exp_t e;
        done     = 1'b0;
        pc       = a;
        pc_valid = 1'b1;
        for (int k = 0; k < 60 && !done; k++) begin
            #1;
            if (pc_ready) begin
                e.pc    = a;
                e.fault = (a[1:0] != 2'b00);
                e.instr = e.fault ? 32'h0000_0013 : mem_word(a);
                exp_q.push_back(e);
                done = 1'b1;
            end
            @(negedge clk);
        end
        pc_valid = 1'b0;
        check("fetch_accept", done, 1);
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            #6;
            ok = (exp_q.size() == 0) && (pend_q.size() == 0);
        end
        check("drain", ok, 1);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, expected end of test");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        pc             = 32'h0;
        pc_valid       = 1'b1;
        flush          = 1'b0;
        imem_req_ready = 1'b1;
        id_ready       = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_id_valid", id_valid, 0);
        check("rst_id_pc", id_pc, 0);
        check("rst_id_instr", id_instr, 0);
        check("rst_id_fault", id_fault, 0);
        check("rst_req_valid", imem_req_valid, 0);
        check("rst_pc_ready", pc_ready, 0);
        pc_valid = 1'b0;
        rst      = 1'b0;
        @(negedge clk);

        // Streaming, one-cycle memory.
        id_ready = 1'b1;
        mem_lat  = 1;
        for (int i = 0; i < 4; i++) fetch(32'(4 * i));
        drain();

        // Backpressure: two entries held, third request blocked.
        id_ready = 1'b0;
        fetch(32'h20);
        fetch(32'h24);
        for (int i = 0; i < 3; i++) begin
            pc       = 32'h28;
            pc_valid = 1'b1;
            #1;
            check("full_pc_ready", pc_ready, 0);
            check("full_req_valid", imem_req_valid, 0);
            @(negedge clk);
        end
        id_ready = 1'b1;
        fetch(32'h28);
        drain();

        // Misaligned fetch.
        pc       = 32'h6;
        pc_valid = 1'b1;
        #1;
        check("mis_pc_ready", pc_ready, 1);
        check("mis_no_req", imem_req_valid, 0);
        exp_q.push_back('{32'h6, 32'h0000_0013, 1'b1});
        @(negedge clk);
        pc_valid = 1'b0;
        #1;
        check("mis_latency_valid", id_valid, 1);
        drain();

        // Flush with two requests in flight.
        mem_lat = 3;
        fetch(32'h10);
        fetch(32'h14);
        flush    = 1'b1;
        pc       = 32'h40;
        pc_valid = 1'b1;
        #1;
        check("flush_pc_ready", pc_ready, 0);
        check("flush_no_req", imem_req_valid, 0);
        exp_q.delete();
        @(negedge clk);
        flush    = 1'b0;
        pc_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("flush_id_valid", id_valid, 0);
            @(negedge clk);
        end
        check("flush_rsp_returned", pend_q.size(), 0);
        fetch(32'h40);
        drain();

        // Credit limit with slow memory.
        mem_lat = 5;
        fetch(32'h80);
        fetch(32'h84);
        for (int i = 0; i < 3; i++) begin
            pc       = 32'h88;
            pc_valid = 1'b1;
            #1;
            check("credit_pc_ready", pc_ready, 0);
            check("credit_req_valid", imem_req_valid, 0);
            check("credit_outstanding", pend_q.size() <= MAX_OUT, 1);
            @(negedge clk);
        end
        pc_valid = 1'b0;
        fetch(32'h88);
        drain();

        // Asynchronous reset with the buffer full.
        mem_lat  = 1;
        id_ready = 1'b0;
        fetch(32'h100);
        fetch(32'h104);
        repeat (3) @(negedge clk);
        check("pre_rst_id_valid", id_valid, 1);
        pc       = 32'h108;
        pc_valid = 1'b1;
        #3;
        rst = 1'b1;
        #1;
        check("arst_id_valid", id_valid, 0);
        check("arst_req_valid", imem_req_valid, 0);
        check("arst_pc_ready", pc_ready, 0);
        exp_q.delete();
        pend_q.delete();
        imem_rsp_valid = 1'b0;
        @(negedge clk);
        #1;
        rst      = 1'b0;
        pc_valid = 1'b0;
        @(negedge clk);
        id_ready = 1'b1;
        fetch(32'h0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
